// File: rtl/key_set_ctrl.sv
// Panel key front-end: sync + debounce three active-low keys and run the clock-setting mode FSM.
// Optional alarm-setting states (AL_H, AL_M) are compiled in with `define ALARM_SET_EN.
module key_set_ctrl #(
    parameter int DEB_CYCLES = 20,
    parameter int TIMEOUT    = 30000
) (
    input  logic       CP,
    input  logic       nCR,
    input  logic       KEY_MODE,
    input  logic       KEY_ADD,
    input  logic       KEY_SUB,
    output logic       H_UP,
    output logic       H_DOWN,
    output logic       M_UP,
    output logic       M_DOWN,
    output logic       S_UP,
    output logic       S_DOWN,
    output logic       PE,
    output logic       LD,
    output logic [2:0] SEL,
    output logic       ALM_SEL
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [IW-1:0] TO_V     = IW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_RUN, S_SET_H, S_SET_M, S_SET_S
`ifdef ALARM_SET_EN
        , S_AL_H, S_AL_M
`endif
    } state_t;

    // key bit order: [0] MODE, [1] ADD, [2] SUB; 1 = released
    logic [2:0]         w_raw;
    logic [2:0]         r_sync1, r_sync2, r_deb, r_deb_d;
    logic [2:0][CW-1:0] r_cnt;
    logic [2:0]         w_press;
    logic               w_any_ev, w_add_held, w_sub_held;

    state_t        r_state, w_nxt;
    logic [IW-1:0] r_idle;
    logic          r_arm, w_arm_nxt;
    logic          w_pe, w_ld, w_up, w_dn;
    logic          w_h_fld, w_m_fld, w_s_fld;
    logic          r_h_up, r_h_dn, r_m_up, r_m_dn, r_s_up, r_s_dn, r_pe, r_ld;

    assign w_raw = {KEY_SUB, KEY_ADD, KEY_MODE};

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_deb   <= '1;
            r_deb_d <= '1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int k = 0; k < 3; k++) begin
                if (r_sync2[k] != r_deb[k]) begin
                    if (r_cnt[k] == DEB_LAST) begin
                        r_deb[k] <= r_sync2[k];
                        r_cnt[k] <= '0;
                    end else begin
                        r_cnt[k] <= r_cnt[k] + CW'(1);
                    end
                end else begin
                    r_cnt[k] <= '0;
                end
            end
        end
    end

    assign w_press    = r_deb_d & ~r_deb;
    assign w_any_ev   = |w_press;
    assign w_add_held = ~r_deb[1];
    assign w_sub_held = ~r_deb[2];

    always_comb begin
        w_nxt = r_state;
        w_pe  = 1'b0;
        w_ld  = 1'b0;
        // timeout wins over a coincident MODE press so only one exit happens
        if (r_state != S_RUN && r_idle == TO_V) begin
            w_nxt = S_RUN;
            w_ld  = (r_state == S_SET_H) || (r_state == S_SET_M) || (r_state == S_SET_S);
        end else if (w_press[0]) begin
            case (r_state)
                S_RUN:   begin w_nxt = S_SET_H; w_pe = 1'b1; end
                S_SET_H: w_nxt = S_SET_M;
                S_SET_M: w_nxt = S_SET_S;
`ifdef ALARM_SET_EN
                S_SET_S: begin w_nxt = S_AL_H; w_ld = 1'b1; end
                S_AL_H:  w_nxt = S_AL_M;
                S_AL_M:  w_nxt = S_RUN;
`else
                S_SET_S: begin w_nxt = S_RUN; w_ld = 1'b1; end
`endif
                default: w_nxt = S_RUN;
            endcase
        end
    end

    // ARM drops on any state change so a key held across MODE cannot adjust the new field
    assign w_arm_nxt = (w_nxt != r_state) ? 1'b0 :
                       (!w_add_held && !w_sub_held) ? 1'b1 : r_arm;
    assign w_up = w_add_held && !w_sub_held && w_arm_nxt;
    assign w_dn = w_sub_held && !w_add_held && w_arm_nxt;

`ifdef ALARM_SET_EN
    assign w_h_fld = (r_state == S_SET_H) || (r_state == S_AL_H);
    assign w_m_fld = (r_state == S_SET_M) || (r_state == S_AL_M);
    assign ALM_SEL = (r_state == S_AL_H) || (r_state == S_AL_M);
`else
    assign w_h_fld = (r_state == S_SET_H);
    assign w_m_fld = (r_state == S_SET_M);
    assign ALM_SEL = 1'b0;
`endif
    assign w_s_fld = (r_state == S_SET_S);

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            r_state <= S_RUN;
            r_idle  <= '0;
            r_arm   <= 1'b0;
            r_h_up  <= 1'b0;
            r_h_dn  <= 1'b0;
            r_m_up  <= 1'b0;
            r_m_dn  <= 1'b0;
            r_s_up  <= 1'b0;
            r_s_dn  <= 1'b0;
            r_pe    <= 1'b0;
            r_ld    <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_arm   <= w_arm_nxt;
            if (w_nxt == S_RUN || w_any_ev)
                r_idle <= '0;
            else if (r_idle != TO_V)
                r_idle <= r_idle + IW'(1);
            r_h_up <= w_h_fld && w_up;
            r_h_dn <= w_h_fld && w_dn;
            r_m_up <= w_m_fld && w_up;
            r_m_dn <= w_m_fld && w_dn;
            r_s_up <= w_s_fld && w_up;
            r_s_dn <= w_s_fld && w_dn;
            r_pe   <= w_pe;
            r_ld   <= w_ld;
        end
    end

    always_comb begin
        SEL = 3'b000;
        if (w_h_fld) SEL = 3'b100;
        if (w_m_fld) SEL = 3'b010;
        if (w_s_fld) SEL = 3'b001;
    end

    assign H_UP   = r_h_up;
    assign H_DOWN = r_h_dn;
    assign M_UP   = r_m_up;
    assign M_DOWN = r_m_dn;
    assign S_UP   = r_s_up;
    assign S_DOWN = r_s_dn;
    assign PE     = r_pe;
    assign LD     = r_ld;
endmodule

// File: tb/tb_key_set_ctrl.sv
// Bench for key_set_ctrl with DEB_CYCLES=4, TIMEOUT=100; table vectors plus timed corner sequences.
module tb_key_set_ctrl;
    logic       CP = 1'b0;
    logic       nCR = 1'b0;
    logic       KEY_MODE = 1'b1, KEY_ADD = 1'b1, KEY_SUB = 1'b1;
    logic       H_UP, H_DOWN, M_UP, M_DOWN, S_UP, S_DOWN, PE, LD, ALM_SEL;
    logic [2:0] SEL;

    key_set_ctrl #(.DEB_CYCLES(4), .TIMEOUT(100)) dut (
        .CP(CP), .nCR(nCR),
        .KEY_MODE(KEY_MODE), .KEY_ADD(KEY_ADD), .KEY_SUB(KEY_SUB),
        .H_UP(H_UP), .H_DOWN(H_DOWN), .M_UP(M_UP), .M_DOWN(M_DOWN),
        .S_UP(S_UP), .S_DOWN(S_DOWN), .PE(PE), .LD(LD), .SEL(SEL), .ALM_SEL(ALM_SEL)
    );

    always #5 CP = ~CP;

    localparam logic [5:0] N0 = 6'b000000, HU = 6'b100000, HD = 6'b010000,
                           MU = 6'b001000, SU = 6'b000010;

    typedef struct {
        logic        mode, add, sub;
        int          cyc;
        logic [11:0] exp;
    } vec_t;

    vec_t        tbl[16];
    logic [11:0] sb[$];
    logic [11:0] w_out;
    int          n_tests = 0, n_fail = 0;
    int          ld_cnt = 0, pe_cnt = 0, ld0, pe0;

    assign w_out = {ALM_SEL, SEL, H_UP, H_DOWN, M_UP, M_DOWN, S_UP, S_DOWN, PE, LD};

    always @(negedge CP) begin
        if (LD) ld_cnt++;
        if (PE) pe_cnt++;
    end

    function automatic logic [11:0] ex(logic alm, logic [2:0] sel, logic [5:0] adj, logic pe, logic ld);
        return {alm, sel, adj, pe, ld};
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge CP);
        #1;
    endtask

    task automatic chk(string nm, logic [11:0] exp);
        n_tests++;
        if (w_out !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, w_out, exp, $time);
        end
    endtask

    task automatic chk_int(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(int lo, int hi);
        for (int i = lo; i <= hi; i++) begin
            KEY_MODE = tbl[i].mode;
            KEY_ADD  = tbl[i].add;
            KEY_SUB  = tbl[i].sub;
            sb.push_back(tbl[i].exp);
            step(tbl[i].cyc);
            chk($sformatf("tbl[%0d]", i), sb.pop_front());
        end
    endtask

    task automatic press_mode();
        KEY_MODE = 1'b0;
        step(10);
        KEY_MODE = 1'b1;
        step(10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // SET_H / SET_M key combinations
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 12, ex(0, 3'b100, HU, 0, 0)};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 12, ex(0, 3'b100, N0, 0, 0)};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 12, ex(0, 3'b100, HU, 0, 0)};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 12, ex(0, 3'b100, N0, 0, 0)};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 12, ex(0, 3'b100, HD, 0, 0)};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 12, ex(0, 3'b100, N0, 0, 0)};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 12, ex(0, 3'b010, N0, 0, 0)};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 12, ex(0, 3'b010, N0, 0, 0)};
        // RUN ignores ADD; MODE together with ADD gives no adjust
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 12, ex(0, 3'b000, N0, 0, 0)};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 12, ex(0, 3'b000, N0, 0, 0)};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 12, ex(0, 3'b100, N0, 0, 0)};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 12, ex(0, 3'b100, N0, 0, 0)};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 12, ex(0, 3'b010, N0, 0, 0)};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 12, ex(0, 3'b010, N0, 0, 0)};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 12, ex(0, 3'b010, MU, 0, 0)};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 12, ex(0, 3'b010, N0, 0, 0)};

        step(3);
        chk("reset", ex(0, 3'b000, N0, 0, 0));
        nCR = 1'b1;
        step(3);
        chk("post_reset", ex(0, 3'b000, N0, 0, 0));

        // bounces shorter than DEB_CYCLES must not register
        for (int b = 0; b < 2; b++) begin
            KEY_MODE = 1'b0; step(3);
            KEY_MODE = 1'b1; step(3);
        end
        chk("bounce_idle", ex(0, 3'b000, N0, 0, 0));
        chk_int("bounce_no_pe", pe_cnt, 0);
        KEY_MODE = 1'b0;
        step(6);
        chk("deb_edge6", ex(0, 3'b000, N0, 0, 0));
        step(1);
        chk("deb_edge7", ex(0, 3'b100, N0, 1, 0));
        step(1);
        chk("deb_edge8", ex(0, 3'b100, N0, 0, 0));
        chk_int("pe_once", pe_cnt, 1);
        KEY_MODE = 1'b1;
        step(10);

        apply(0, 7);

        // 50-cycle ADD hold in SET_M, cycle exact
        KEY_ADD = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 51) KEY_ADD = 1'b1;
            step(1);
            chk("m_hold", ex(0, 3'b010, (k >= 7 && k <= 56) ? MU : N0, 0, 0));
        end
        step(5);

        // ADD held through MODE does not adjust the new field
        KEY_ADD = 1'b0; step(12);
        chk("hold_pre", ex(0, 3'b010, MU, 0, 0));
        KEY_MODE = 1'b0; step(8);
        chk("hold_mode", ex(0, 3'b001, N0, 0, 0));
        KEY_MODE = 1'b1; step(12);
        chk("hold_keep", ex(0, 3'b001, N0, 0, 0));
        KEY_ADD = 1'b1; step(12);
        chk("hold_rel", ex(0, 3'b001, N0, 0, 0));

        // re-press arms S_UP, then idle into timeout
        ld0 = ld_cnt;
        KEY_ADD = 1'b0; step(12);
        chk("to_sup", ex(0, 3'b001, SU, 0, 0));
        KEY_ADD = 1'b1; step(12);
        chk("to_rel", ex(0, 3'b001, N0, 0, 0));
        step(83);
        chk("to_before", ex(0, 3'b001, N0, 0, 0));
        step(1);
        chk("to_exit", ex(0, 3'b000, N0, 0, 1));
        step(1);
        chk("to_after", ex(0, 3'b000, N0, 0, 0));
        chk_int("to_ld_once", ld_cnt - ld0, 1);

        apply(8, 15);

        // async reset in SET_M: immediate clear, no LD
        ld0 = ld_cnt;
        nCR = 1'b0;
        #1;
        chk("ncr_async", ex(0, 3'b000, N0, 0, 0));
        step(3);
        chk("ncr_hold", ex(0, 3'b000, N0, 0, 0));
        nCR = 1'b1;
        step(10);
        chk("ncr_after", ex(0, 3'b000, N0, 0, 0));
        chk_int("ncr_no_ld", ld_cnt - ld0, 0);

        // full MODE cycle
        ld0 = ld_cnt;
        pe0 = pe_cnt;
        press_mode(); chk("cyc1", ex(0, 3'b100, N0, 0, 0));
        press_mode(); chk("cyc2", ex(0, 3'b010, N0, 0, 0));
        press_mode(); chk("cyc3", ex(0, 3'b001, N0, 0, 0));
`ifdef ALARM_SET_EN
        press_mode(); chk("cyc4_alh", ex(1, 3'b100, N0, 0, 0));
        chk_int("cyc_ld_once", ld_cnt - ld0, 1);
        press_mode(); chk("cyc5_alm", ex(1, 3'b010, N0, 0, 0));
        press_mode(); chk("cyc6_run", ex(0, 3'b000, N0, 0, 0));
        chk_int("cyc_ld_final", ld_cnt - ld0, 1);
`else
        press_mode(); chk("cyc4_run", ex(0, 3'b000, N0, 0, 0));
        chk_int("cyc_ld_once", ld_cnt - ld0, 1);
`endif
        chk_int("cyc_pe_once", pe_cnt - pe0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
